// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: per-bit synchroniser into CLOCK_50 plus an
// independent debounce counter, with registered clean levels and edge pulses.
module sw_debounce_sync #(
  parameter  int WIDTH           = 10,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_CLEAN,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   clean_reg;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   sync_out;

      assign sync_out = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
          sync_reg  <= '0;
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], SW[gi]};
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          // Any agreement with the accepted level restarts the whole window.
          if (sync_out == clean_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            clean_reg <= sync_out;
            cnt_reg   <= '0;
            rise_reg  <= sync_out;
            fall_reg  <= ~sync_out;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign SW_CLEAN[gi] = clean_reg;
      assign SW_RISE[gi]  = rise_reg;
      assign SW_FALL[gi]  = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with DEBOUNCE_CYCLES=4; expected
// output snapshots are queued with their target cycle and checked on arrival.
module tb_sw_debounce_sync;

  logic       clk;
  logic       key0;
  logic [9:0] sw;
  logic [9:0] sw_clean;
  logic [9:0] sw_rise;
  logic [9:0] sw_fall;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base;

  typedef struct {
    int         cyc;
    string      tag;
    logic [9:0] clean;
    logic [9:0] rise;
    logic [9:0] fall;
  } exp_t;

  exp_t sb[$];

  sw_debounce_sync #(
    .WIDTH(10),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .KEY0(key0),
    .SW(sw),
    .SW_CLEAN(sw_clean),
    .SW_RISE(sw_rise),
    .SW_FALL(sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] cl,
                       input logic [9:0] r, input logic [9:0] f);
    checks++;
    assert ({sw_clean, sw_rise, sw_fall} === {cl, r, f}) else begin
      failures++;
      $error("FAIL %s cyc=%0d got clean=%h rise=%h fall=%h expected clean=%h rise=%h fall=%h",
             tag, cyc, sw_clean, sw_rise, sw_fall, cl, r, f);
    end
  endtask

  task automatic push_exp(input int c, input string tag, input logic [9:0] cl,
                          input logic [9:0] r, input logic [9:0] f);
    exp_t e;
    e.cyc   = c;
    e.tag   = tag;
    e.clean = cl;
    e.rise  = r;
    e.fall  = f;
    sb.push_back(e);
  endtask

  // Queue quiet cycles (no pulses) over relative edges lo..hi.
  task automatic push_hold(input int lo, input int hi, input string tag,
                           input logic [9:0] cl);
    for (int k = lo; k <= hi; k++) push_exp(base + k, tag, cl, 10'h000, 10'h000);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check(e.tag, e.clean, e.rise, e.fall);
      end
    end
  endtask

  initial begin
    key0 = 1'b1;
    sw   = 10'h000;
    #1;
    // Asynchronous reset with all switches up, no clock edge yet.
    sw   = 10'h3FF;
    key0 = 1'b0;
    #1;
    check("reset_async", 10'h000, 10'h000, 10'h000);
    sw = 10'h000;
    base = cyc;
    push_hold(1, 3, "reset_hold", 10'h000);
    run(3);

    // Clean rising step on bit 0.
    key0 = 1'b1;
    sw   = 10'h001;
    base = cyc;
    push_hold(1, 5, "step_wait", 10'h000);
    push_exp(base + 6, "step_rise", 10'h001, 10'h001, 10'h000);
    push_exp(base + 7, "step_after", 10'h001, 10'h000, 10'h000);
    run(7);

    // Bounce on bit 3: 3-cycle pulses never accepted, final level is.
    base = cyc;
    push_hold(1, 17, "bounce_hold", 10'h001);
    push_exp(base + 18, "bounce_rise", 10'h009, 10'h008, 10'h000);
    push_exp(base + 19, "bounce_after", 10'h009, 10'h000, 10'h000);
    sw = 10'h009; run(3);
    sw = 10'h001; run(3);
    sw = 10'h009; run(3);
    sw = 10'h001; run(3);
    sw = 10'h009; run(7);

    // Drop bit 3 again so SW_CLEAN is 10'h001.
    sw   = 10'h001;
    base = cyc;
    push_hold(1, 5, "clr3_wait", 10'h009);
    push_exp(base + 6, "clr3_fall", 10'h001, 10'h000, 10'h008);
    run(7);

    // Falling edge on bit 0.
    sw   = 10'h000;
    base = cyc;
    push_hold(1, 5, "fall_wait", 10'h001);
    push_exp(base + 6, "fall_pulse", 10'h000, 10'h000, 10'h001);
    push_exp(base + 7, "fall_after", 10'h000, 10'h000, 10'h000);
    run(7);

    // Two bits rise together, then fall together.
    sw   = 10'h210;
    base = cyc;
    push_hold(1, 5, "multi_wait", 10'h000);
    push_exp(base + 6, "multi_rise", 10'h210, 10'h210, 10'h000);
    push_exp(base + 7, "multi_after", 10'h210, 10'h000, 10'h000);
    run(7);
    sw   = 10'h000;
    base = cyc;
    push_exp(base + 6, "multi_fall", 10'h000, 10'h000, 10'h210);
    push_exp(base + 7, "multi_fall_after", 10'h000, 10'h000, 10'h000);
    run(7);

    // Reset pulsed across edge 3 while bit 9 is held high.
    sw   = 10'h200;
    base = cyc;
    push_hold(1, 8, "midrst_hold", 10'h000);
    push_exp(base + 9, "midrst_rise", 10'h200, 10'h200, 10'h000);
    push_exp(base + 10, "midrst_after", 10'h200, 10'h000, 10'h000);
    run(2);
    key0 = 1'b0;
    run(1);
    key0 = 1'b1;
    run(7);

    // Asynchronous assertion mid-cycle clears a set output immediately.
    run(2);
    #2;
    key0 = 1'b0;
    #1;
    check("reset_midcycle", 10'h000, 10'h000, 10'h000);
    run(2);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
